cal_sequence_scheduler: RTL and testbench

//  Sequences the four-direction calibration engine and shares the feature-frame strobe between the

---
 rtl/cal_sequence_scheduler_if.sv | 25 ++
 rtl/cal_sequence_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_cal_sequence_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cal_sequence_scheduler_if.sv
// Frame-strobe and control bundle between the scheduler, the frame pipeline,
// the calibration engine and the cursor mapper.
interface cal_sequence_scheduler_if;
    logic       req_cal;
    logic       abort;
    logic       frame_valid;
    logic       cal_calibrated;
    logic       start_cal;
    logic       cal_valid;
    logic       run_valid;
    logic [2:0] cue;
    logic [2:0] phase;
    logic       busy;
    logic [1:0] fault_code;

    modport master (
        output req_cal, abort, frame_valid, cal_calibrated,
        input  start_cal, cal_valid, run_valid, cue, phase, busy, fault_code
    );

    modport slave (
        input  req_cal, abort, frame_valid, cal_calibrated,
        output start_cal, cal_valid, run_valid, cue, phase, busy, fault_code
    );
endinterface

// File: rtl/cal_sequence_scheduler.sv
// Four-direction calibration sequencer with settle discard and timeout supervision.
// Optional AUTO_RECAL_EN: recalibrate automatically every RECAL_FRAMES run frames.
module cal_sequence_scheduler #(
    parameter int unsigned CAL_SAMPLES   = 64,
    parameter int unsigned SETTLE_FRAMES = 16,
    parameter int unsigned TIMEOUT_CYC   = 1_000_000,
    parameter int unsigned RECAL_FRAMES  = 65_536
) (
    input logic                     clk,
    input logic                     rst,
    cal_sequence_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_CHECK  = 3'd4,
        S_RUN    = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [15:0] SAMP_LAST = 16'(CAL_SAMPLES - 1);
    localparam logic [15:0] SETL_LAST = 16'(SETTLE_FRAMES - 1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  DIR_DOWN  = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  dir_q, dir_d;
    logic [2:0]  cue_q, cue_d;
    logic [15:0] frm_q, frm_d;
    logic [23:0] to_q, to_d;
    logic [1:0]  sc_q, sc_d;
    logic        restart_q, restart_d;
    logic        start_q, start_d;
    logic [1:0]  fault_q, fault_d;
    logic        busy_q, busy_d;
    logic        go_start;
    logic        timed_out;
    logic        run_v;
    logic        recal_hit;

    assign run_v     = bus.frame_valid && (state_q == S_RUN);
    assign timed_out = !bus.frame_valid && (to_q == TO_LAST);

`ifdef AUTO_RECAL_EN
    localparam logic [31:0] RECAL_LAST = 32'(RECAL_FRAMES - 1);
    logic [31:0] recal_q;

    assign recal_hit = run_v && (recal_q == RECAL_LAST);

    // Held at zero outside RUN, so every entry to RUN starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   recal_q <= '0;
        else if (state_q != S_RUN) recal_q <= '0;
        else if (recal_hit)        recal_q <= '0;
        else if (run_v)            recal_q <= recal_q + 32'd1;
    end
`else
    assign recal_hit = 1'b0 & (RECAL_FRAMES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cue_d     = cue_q;
        frm_d     = frm_q;
        sc_d      = sc_q;
        restart_d = restart_q;
        start_d   = 1'b0;
        fault_d   = fault_q;
        go_start  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_cal) go_start = 1'b1;
            end
            S_START: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (restart_q && sc_q != 2'd2) begin
                    sc_d    = sc_q + 2'd1;
                    start_d = (sc_q == 2'd1);
                end else begin
                    dir_d   = 3'd1;
                    cue_d   = 3'd1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (SETTLE_FRAMES == 0) begin
                    state_d = S_ACQ;
                end else if (bus.frame_valid) begin
                    if (frm_q == SETL_LAST) state_d = S_ACQ;
                    else frm_d = frm_q + 16'd1;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'd1;
                end
            end
            S_ACQ: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.frame_valid) begin
                    if (frm_q != SAMP_LAST) begin
                        frm_d = frm_q + 16'd1;
                    end else if (dir_q < DIR_DOWN) begin
                        dir_d   = dir_q + 3'd1;
                        cue_d   = cue_q + 3'd1;
                        state_d = S_SETTLE;
                    end else begin
                        cue_d   = 3'd0;
                        state_d = S_CHECK;
                    end
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'd1;
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.cal_calibrated) begin
                    state_d = S_RUN;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 2'd2;
                end
            end
            S_RUN: begin
                if (bus.req_cal || recal_hit) go_start = 1'b1;
            end
            S_FAULT: begin
                if (bus.abort) state_d = S_IDLE;
                else if (bus.req_cal) go_start = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // An engine already reporting calibrated gets a second start pulse.
        if (go_start) begin
            state_d   = S_START;
            start_d   = 1'b1;
            restart_d = bus.cal_calibrated;
            sc_d      = 2'd0;
        end
        if (state_d != state_q) frm_d = '0;
        if (state_d == S_IDLE || state_d == S_FAULT) cue_d = 3'd0;
        if (state_d == S_IDLE) dir_d = 3'd0;
        if (state_q == S_FAULT && state_d != S_FAULT) fault_d = 2'd0;

        if (state_d != state_q || bus.frame_valid) to_d = '0;
        else if (state_q == S_SETTLE || state_q == S_ACQ
                 || state_q == S_CHECK) to_d = to_q + 24'd1;
        else to_d = '0;

        busy_d = (state_d == S_START) || (state_d == S_SETTLE)
              || (state_d == S_ACQ)   || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= '0;
            cue_q     <= '0;
            frm_q     <= '0;
            to_q      <= '0;
            sc_q      <= '0;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
            fault_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cue_q     <= cue_d;
            frm_q     <= frm_d;
            to_q      <= to_d;
            sc_q      <= sc_d;
            restart_q <= restart_d;
            start_q   <= start_d;
            fault_q   <= fault_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.start_cal  = start_q;
    assign bus.cal_valid  = bus.frame_valid && (state_q == S_ACQ);
    assign bus.run_valid  = run_v;
    assign bus.cue        = cue_q;
    assign bus.phase      = state_q;
    assign bus.busy       = busy_q;
    assign bus.fault_code = fault_q;
endmodule

// File: tb/tb_cal_sequence_scheduler.sv
// Directed bench for cal_sequence_scheduler (CAL_SAMPLES=4, SETTLE=2, TIMEOUT=100).
// Build with +define+AUTO_RECAL_EN to exercise automatic recalibration.
module tb_cal_sequence_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic cv, rv;

    always #5 clk = ~clk;

    cal_sequence_scheduler_if bus ();

    cal_sequence_scheduler #(
        .CAL_SAMPLES  (4),
        .SETTLE_FRAMES(2),
        .TIMEOUT_CYC  (100),
        .RECAL_FRAMES (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(output logic c, output logic r);
        bus.frame_valid = 1'b1;
        #1;
        c = bus.cal_valid;
        r = bus.run_valid;
        step();
        bus.frame_valid = 1'b0;
        step();
    endtask

    task automatic request();
        bus.req_cal = 1'b1;
        step();
        bus.req_cal = 1'b0;
    endtask

    initial begin
        bus.req_cal        = 1'b0;
        bus.abort          = 1'b0;
        bus.frame_valid    = 1'b0;
        bus.cal_calibrated = 1'b0;
        step();
        step();
        chk("rst_phase", bus.phase, 0);
        chk("rst_cue", bus.cue, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.start_cal, 0);
        chk("rst_fault", bus.fault_code, 0);
        rst = 1'b0;
        step();

        // Full calibration pass
        request();
        chk("t1_start_phase", bus.phase, 1);
        chk("t1_start_pulse", bus.start_cal, 1);
        chk("t1_busy", bus.busy, 1);
        step();
        chk("t1_settle", bus.phase, 2);
        chk("t1_start_done", bus.start_cal, 0);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("t1_cue%0d", k), bus.cue, k / 6 + 1);
            frame(cv, rv);
            chk($sformatf("t1_cv%0d", k), cv, (k % 6) >= 2);
            chk($sformatf("t1_rv%0d", k), rv, 0);
        end
        chk("t1_check", bus.phase, 4);
        chk("t1_check_cue", bus.cue, 0);
        frame(cv, rv);
        chk("t1_check_cv", cv, 0);
        chk("t1_check_rv", rv, 0);
        bus.cal_calibrated = 1'b1;
        step();
        chk("t1_run", bus.phase, 5);
        chk("t1_run_busy", bus.busy, 0);
        chk("t1_run_idle_rv", bus.run_valid, 0);
        frame(cv, rv);
        chk("t1_run_rv", rv, 1);
        chk("t1_run_cv", cv, 0);

        // Recalibration from RUN with engine already calibrated
        request();
        chk("t4_pulse_t", bus.start_cal, 1);
        chk("t4_phase_t", bus.phase, 1);
        step();
        chk("t4_pulse_t1", bus.start_cal, 0);
        step();
        chk("t4_pulse_t2", bus.start_cal, 1);
        step();
        chk("t4_pulse_t3", bus.start_cal, 0);
        chk("t4_settle", bus.phase, 2);
        chk("t4_cue", bus.cue, 1);
        bus.cal_calibrated = 1'b0;

        // abort beats req_cal in SETTLE
        bus.abort   = 1'b1;
        bus.req_cal = 1'b1;
        step();
        bus.abort   = 1'b0;
        bus.req_cal = 1'b0;
        chk("t4_abort_phase", bus.phase, 0);
        chk("t4_abort_cue", bus.cue, 0);
        chk("t4_abort_start", bus.start_cal, 0);
        step();
        chk("t4_abort_hold", bus.phase, 0);
        chk("t4_abort_nostart", bus.start_cal, 0);

        // Frame timeout in ACQ
        request();
        step();
        frame(cv, rv);
        frame(cv, rv);
        chk("t2_acq", bus.phase, 3);
        for (int i = 0; i < 98; i++) step();
        chk("t2_before_to", bus.phase, 3);
        step();
        chk("t2_fault", bus.phase, 6);
        chk("t2_code", bus.fault_code, 1);
        chk("t2_cue", bus.cue, 0);
        chk("t2_busy", bus.busy, 0);
        frame(cv, rv);
        chk("t2_fault_cv", cv, 0);
        chk("t2_fault_rv", rv, 0);
        request();
        chk("t2_restart", bus.phase, 1);
        chk("t2_code_clr", bus.fault_code, 0);
        step();
        chk("t2_cue1", bus.cue, 1);

        // Engine timeout in CHECK
        for (int k = 0; k < 24; k++) frame(cv, rv);
        chk("t3_check", bus.phase, 4);
        for (int i = 0; i < 98; i++) step();
        chk("t3_before_to", bus.phase, 4);
        step();
        chk("t3_fault", bus.phase, 6);
        chk("t3_code", bus.fault_code, 2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t3_abort", bus.phase, 0);
        chk("t3_code_clr", bus.fault_code, 0);

        // Asynchronous reset in ACQ
        request();
        step();
        for (int k = 0; k < 3; k++) frame(cv, rv);
        chk("t5_acq", bus.phase, 3);
        #2;
        bus.frame_valid = 1'b1;
        #1;
        chk("t5_pre_cv", bus.cal_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_phase", bus.phase, 0);
        chk("t5_cue", bus.cue, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_cv", bus.cal_valid, 0);
        chk("t5_start", bus.start_cal, 0);
        bus.frame_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            frame(cv, rv);
            chk($sformatf("t5_idle_cv%0d", k), cv, 0);
            chk($sformatf("t5_idle_rv%0d", k), rv, 0);
        end
        chk("t5_idle", bus.phase, 0);

        // RUN exit behaviour
        request();
        step();
        for (int k = 0; k < 24; k++) frame(cv, rv);
        bus.cal_calibrated = 1'b1;
        step();
        chk("t6_run", bus.phase, 5);
`ifdef AUTO_RECAL_EN
        for (int k = 0; k < 7; k++) frame(cv, rv);
        chk("t6_before_recal", bus.phase, 5);
        frame(cv, rv);
        chk("t6_recal_rv", rv, 1);
        chk("t6_recal", bus.phase, 1);
`else
        for (int k = 0; k < 100; k++) frame(cv, rv);
        chk("t6_last_rv", rv, 1);
        chk("t6_stay", bus.phase, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
